// File: rtl/mem_issue_queue_if.sv
// Dispatch, writeback-broadcast and issue signals of the memory issue queue.
// The master side drives dispatch and writeback; the slave side is the queue itself.
interface mem_issue_queue_if #(
  parameter int PTR_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_ope;
  logic [31:0]      in_ds_val;
  logic             in_ds_rdy;
  logic [5:0]       in_ds_tag;
  logic [31:0]      in_dt_val;
  logic             in_dt_rdy;
  logic [5:0]       in_dt_tag;
  logic [5:0]       in_dd;
  logic [15:0]      in_imm;
  logic [5:0]       wb_tag;
  logic [31:0]      wb_val;
  logic [5:0]       ope;
  logic [31:0]      ds_val;
  logic [31:0]      dt_val;
  logic [5:0]       dd;
  logic [15:0]      imm;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_ope, in_ds_val, in_ds_rdy, in_ds_tag,
           in_dt_val, in_dt_rdy, in_dt_tag, in_dd, in_imm, wb_tag, wb_val,
    input  in_ready, ope, ds_val, dt_val, dd, imm, count
  );

  modport slave (
    input  in_valid, in_ope, in_ds_val, in_ds_rdy, in_ds_tag,
           in_dt_val, in_dt_rdy, in_dt_tag, in_dd, in_imm, wb_tag, wb_val,
    output in_ready, ope, ds_val, dt_val, dd, imm, count
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue buffer: captures pending operands from the writeback
// broadcast and issues the head op once both operands are available.
module mem_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic             clk,
  input logic             rstn,
  mem_issue_queue_if.slave q
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [5:0]  e_ope    [DEPTH];
  logic [31:0] e_ds_val [DEPTH];
  logic        e_ds_rdy [DEPTH];
  logic [5:0]  e_ds_tag [DEPTH];
  logic [31:0] e_dt_val [DEPTH];
  logic        e_dt_rdy [DEPTH];
  logic [5:0]  e_dt_tag [DEPTH];
  logic [5:0]  e_dd     [DEPTH];
  logic [15:0] e_imm    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;

  logic             wb_on;
  logic             enq;
  logic             iss;
  logic             hit_ds;
  logic             hit_dt;
  logic [31:0]      ds_now;
  logic [31:0]      dt_now;
  logic             cap_ds;
  logic             cap_dt;
  logic [DEPTH-1:0] live;

  assign q.in_ready = (cnt != FULL);
  assign q.count    = cnt;
  assign wb_on      = (q.wb_tag != 6'd0);
  assign enq        = q.in_valid && q.in_ready;
  assign cap_ds     = !q.in_ds_rdy && wb_on && (q.in_ds_tag == q.wb_tag);
  assign cap_dt     = !q.in_dt_rdy && wb_on && (q.in_dt_tag == q.wb_tag);

  // Head readiness includes the live broadcast so a wakeup issues with zero added latency.
  always_comb begin
    hit_ds = wb_on && !e_ds_rdy[head] && (e_ds_tag[head] == q.wb_tag);
    hit_dt = wb_on && !e_dt_rdy[head] && (e_dt_tag[head] == q.wb_tag);
    ds_now = hit_ds ? q.wb_val : e_ds_val[head];
    dt_now = hit_dt ? q.wb_val : e_dt_val[head];
    iss    = (cnt != '0) && (e_ds_rdy[head] || hit_ds) && (e_dt_rdy[head] || hit_dt);
  end

  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offs;
      offs    = PTR_W'(i) - head;
      live[i] = ({1'b0, offs} < cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      q.ope    <= '0;
      q.ds_val <= '0;
      q.dt_val <= '0;
      q.dd     <= '0;
      q.imm    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_ds_rdy[i] <= 1'b0;
        e_dt_rdy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live[i] && wb_on) begin
          if (!e_ds_rdy[i] && (e_ds_tag[i] == q.wb_tag)) begin
            e_ds_val[i] <= q.wb_val;
            e_ds_rdy[i] <= 1'b1;
          end
          if (!e_dt_rdy[i] && (e_dt_tag[i] == q.wb_tag)) begin
            e_dt_val[i] <= q.wb_val;
            e_dt_rdy[i] <= 1'b1;
          end
        end
      end

      // The tail slot is never live when in_ready is high, so this write cannot collide with a wakeup.
      if (enq) begin
        e_ope[tail]    <= q.in_ope;
        e_ds_val[tail] <= cap_ds ? q.wb_val : q.in_ds_val;
        e_ds_rdy[tail] <= q.in_ds_rdy || cap_ds;
        e_ds_tag[tail] <= q.in_ds_tag;
        e_dt_val[tail] <= cap_dt ? q.wb_val : q.in_dt_val;
        e_dt_rdy[tail] <= q.in_dt_rdy || cap_dt;
        e_dt_tag[tail] <= q.in_dt_tag;
        e_dd[tail]     <= q.in_dd;
        e_imm[tail]    <= q.in_imm;
        tail           <= tail + 1'b1;
      end

      if (iss) begin
        q.ope    <= e_ope[head];
        q.ds_val <= ds_now;
        q.dt_val <= dt_now;
        q.dd     <= e_dd[head];
        q.imm    <= e_imm[head];
        head     <= head + 1'b1;
      end else begin
        q.ope    <= '0;
        q.ds_val <= '0;
        q.dt_val <= '0;
        q.dd     <= '0;
        q.imm    <= '0;
      end

      case ({enq, iss})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed test of mem_issue_queue: reset, issue latency, wakeup ordering,
// same-cycle capture, full/wrap and simultaneous enqueue/issue.
module tb_mem_issue_queue;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  mem_issue_queue_if #(.PTR_W(2)) ifq ();

  mem_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .q    (ifq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifq.in_valid  = 1'b0;
    ifq.in_ope    = '0;
    ifq.in_ds_val = '0;
    ifq.in_ds_rdy = 1'b1;
    ifq.in_ds_tag = 6'd1;
    ifq.in_dt_val = '0;
    ifq.in_dt_rdy = 1'b1;
    ifq.in_dt_tag = 6'd1;
    ifq.in_dd     = '0;
    ifq.in_imm    = '0;
    ifq.wb_tag    = '0;
    ifq.wb_val    = '0;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] dsv, input logic dsr,
                        input logic [5:0] dst, input logic [31:0] dtv, input logic dtr,
                        input logic [5:0] dtt, input logic [5:0] d, input logic [15:0] im);
    ifq.in_valid  = 1'b1;
    ifq.in_ope    = op;
    ifq.in_ds_val = dsv;
    ifq.in_ds_rdy = dsr;
    ifq.in_ds_tag = dst;
    ifq.in_dt_val = dtv;
    ifq.in_dt_rdy = dtr;
    ifq.in_dt_tag = dtt;
    ifq.in_dd     = d;
    ifq.in_imm    = im;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_op(6'h08, 32'h1, 1'b1, 6'd1, 32'h2, 1'b1, 6'd1, 6'd3, 16'h9);
    tick();
    tick();
    total++;
    if ({ifq.count, ifq.ope, ifq.dd} !== {3'd0, 6'd0, 6'd0}) begin
      $display("[TB] FAIL reset_state: count/ope/dd got %0d/%h/%0d want 0/00/0", ifq.count, ifq.ope, ifq.dd);
      bad++;
    end
    idle();
    rstn = 1'b1;
    #1;
    total++;
    if (ifq.in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_in_ready: got %b want 1", ifq.in_ready);
      bad++;
    end
  endtask

  task automatic test_ready_load();
    set_op(6'h08, 32'h100, 1'b1, 6'd1, 32'h0, 1'b1, 6'd1, 6'd5, 16'd4);
    tick();
    idle();
    total++;
    if ({ifq.count, ifq.ope} !== {3'd1, 6'h00}) begin
      $display("[TB] FAIL load_enq_edge: count/ope got %0d/%h want 1/00", ifq.count, ifq.ope);
      bad++;
    end
    tick();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.imm, ifq.dd, ifq.count} !== {6'h08, 32'h100, 16'd4, 6'd5, 3'd0}) begin
      $display("[TB] FAIL load_issue: ope/ds/imm/dd/count got %h/%h/%h/%0d/%0d want 08/100/4/5/0",
               ifq.ope, ifq.ds_val, ifq.imm, ifq.dd, ifq.count);
      bad++;
    end
    tick();
    total++;
    if ({ifq.ope, ifq.dd, ifq.ds_val} !== {6'h00, 6'd0, 32'h0}) begin
      $display("[TB] FAIL load_bubble: ope/dd/ds got %h/%0d/%h want 00/0/0", ifq.ope, ifq.dd, ifq.ds_val);
      bad++;
    end
  endtask

  task automatic test_wakeup_order();
    set_op(6'h08, 32'hDEAD, 1'b0, 6'd7, 32'h0, 1'b1, 6'd1, 6'd1, 16'd1);
    tick();
    set_op(6'h09, 32'h44, 1'b1, 6'd1, 32'h0, 1'b1, 6'd1, 6'd2, 16'd2);
    tick();
    idle();
    total++;
    if ({ifq.count, ifq.ope} !== {3'd2, 6'h00}) begin
      $display("[TB] FAIL wake_held: count/ope got %0d/%h want 2/00", ifq.count, ifq.ope);
      bad++;
    end
    tick();
    total++;
    if ({ifq.count, ifq.ope, ifq.dd} !== {3'd2, 6'h00, 6'd0}) begin
      $display("[TB] FAIL wake_bubble: count/ope/dd got %0d/%h/%0d want 2/00/0", ifq.count, ifq.ope, ifq.dd);
      bad++;
    end
    ifq.wb_tag = 6'd7;
    ifq.wb_val = 32'h20;
    tick();
    idle();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.dd, ifq.imm, ifq.count} !== {6'h08, 32'h20, 6'd1, 16'd1, 3'd1}) begin
      $display("[TB] FAIL wake_issue_a: ope/ds/dd/imm/count got %h/%h/%0d/%0d/%0d want 08/20/1/1/1",
               ifq.ope, ifq.ds_val, ifq.dd, ifq.imm, ifq.count);
      bad++;
    end
    tick();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.dd, ifq.count} !== {6'h09, 32'h44, 6'd2, 3'd0}) begin
      $display("[TB] FAIL wake_issue_b: ope/ds/dd/count got %h/%h/%0d/%0d want 09/44/2/0",
               ifq.ope, ifq.ds_val, ifq.dd, ifq.count);
      bad++;
    end
  endtask

  task automatic test_same_cycle_capture();
    set_op(6'h0A, 32'h0, 1'b0, 6'd3, 32'h0, 1'b1, 6'd1, 6'd6, 16'd8);
    ifq.wb_tag = 6'd3;
    ifq.wb_val = 32'hAB;
    tick();
    idle();
    total++;
    if ({ifq.count, ifq.ope} !== {3'd1, 6'h00}) begin
      $display("[TB] FAIL capture_enq: count/ope got %0d/%h want 1/00", ifq.count, ifq.ope);
      bad++;
    end
    tick();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.dd, ifq.count} !== {6'h0A, 32'hAB, 6'd6, 3'd0}) begin
      $display("[TB] FAIL capture_issue: ope/ds/dd/count got %h/%h/%0d/%0d want 0A/AB/6/0",
               ifq.ope, ifq.ds_val, ifq.dd, ifq.count);
      bad++;
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 1; i <= 4; i++) begin
      set_op(6'(i), 32'h0, 1'b0, 6'd10, 32'(i), 1'b1, 6'd1, 6'd0, 16'(i));
      tick();
    end
    set_op(6'h05, 32'h5, 1'b1, 6'd1, 32'h5, 1'b1, 6'd1, 6'd0, 16'd5);
    #1;
    total++;
    if ({ifq.count, ifq.in_ready} !== {3'd4, 1'b0}) begin
      $display("[TB] FAIL full_flag: count/in_ready got %0d/%b want 4/0", ifq.count, ifq.in_ready);
      bad++;
    end
    tick();
    idle();
    total++;
    if ({ifq.count, ifq.ope} !== {3'd4, 6'h00}) begin
      $display("[TB] FAIL full_drop: count/ope got %0d/%h want 4/00", ifq.count, ifq.ope);
      bad++;
    end
    ifq.wb_tag = 6'd10;
    ifq.wb_val = 32'h77;
    for (int i = 1; i <= 4; i++) begin
      tick();
      idle();
      total++;
      if ({ifq.ope, ifq.ds_val, ifq.dt_val, ifq.imm, ifq.count} !== {6'(i), 32'h77, 32'(i), 16'(i), 3'(4 - i)}) begin
        $display("[TB] FAIL full_issue_%0d: ope/ds/dt/imm/count got %h/%h/%h/%0d/%0d want %h/77/%h/%0d/%0d",
                 i, ifq.ope, ifq.ds_val, ifq.dt_val, ifq.imm, ifq.count, i, i, i, 4 - i);
        bad++;
      end
    end
    tick();
    total++;
    if ({ifq.ope, ifq.count} !== {6'h00, 3'd0}) begin
      $display("[TB] FAIL full_dropped_absent: ope/count got %h/%0d want 00/0", ifq.ope, ifq.count);
      bad++;
    end

    // Second fill reuses every slot, so both pointers wrap again.
    for (int i = 0; i < 4; i++) begin
      set_op(6'(6'h18 + i), 32'h0, 1'b0, 6'd20, 32'h0, 1'b0, 6'd21, 6'(8 + i), 16'h0);
      tick();
    end
    idle();
    ifq.wb_tag = 6'd20;
    ifq.wb_val = 32'h55;
    tick();
    idle();
    total++;
    if ({ifq.ope, ifq.count} !== {6'h00, 3'd4}) begin
      $display("[TB] FAIL wrap_half_ready: ope/count got %h/%0d want 00/4", ifq.ope, ifq.count);
      bad++;
    end
    ifq.wb_tag = 6'd21;
    ifq.wb_val = 32'h66;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      total++;
      if ({ifq.ope, ifq.ds_val, ifq.dt_val, ifq.dd} !== {6'(6'h18 + i), 32'h55, 32'h66, 6'(8 + i)}) begin
        $display("[TB] FAIL wrap_issue_%0d: ope/ds/dt/dd got %h/%h/%h/%0d want %h/55/66/%0d",
                 i, ifq.ope, ifq.ds_val, ifq.dt_val, ifq.dd, 6'h18 + i, 8 + i);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_op(6'(6'h30 + i), 32'h0, 1'b0, 6'd30, 32'h0, 1'b1, 6'd1, 6'd0, 16'h0);
      tick();
    end
    set_op(6'h3F, 32'h1, 1'b1, 6'd1, 32'h1, 1'b1, 6'd1, 6'd0, 16'h0);
    ifq.wb_tag = 6'd30;
    ifq.wb_val = 32'h3;
    tick();
    idle();
    total++;
    if ({ifq.ope, ifq.count} !== {6'h30, 3'd3}) begin
      $display("[TB] FAIL full_enq_issue: ope/count got %h/%0d want 30/3", ifq.ope, ifq.count);
      bad++;
    end
    tick();
    tick();
    tick();
    total++;
    if ({ifq.ope, ifq.count} !== {6'h33, 3'd0}) begin
      $display("[TB] FAIL full_enq_drain: ope/count got %h/%0d want 33/0", ifq.ope, ifq.count);
      bad++;
    end

    set_op(6'h21, 32'h0, 1'b0, 6'd40, 32'h0, 1'b1, 6'd1, 6'd0, 16'h0);
    tick();
    set_op(6'h22, 32'h0, 1'b0, 6'd40, 32'h0, 1'b1, 6'd1, 6'd0, 16'h0);
    tick();
    set_op(6'h23, 32'hC, 1'b1, 6'd1, 32'h0, 1'b1, 6'd1, 6'd0, 16'h0);
    ifq.wb_tag = 6'd40;
    ifq.wb_val = 32'h99;
    tick();
    idle();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.count} !== {6'h21, 32'h99, 3'd2}) begin
      $display("[TB] FAIL cnt2_enq_issue: ope/ds/count got %h/%h/%0d want 21/99/2", ifq.ope, ifq.ds_val, ifq.count);
      bad++;
    end
    tick();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.count} !== {6'h22, 32'h99, 3'd1}) begin
      $display("[TB] FAIL cnt2_second: ope/ds/count got %h/%h/%0d want 22/99/1", ifq.ope, ifq.ds_val, ifq.count);
      bad++;
    end
    set_op(6'h24, 32'hD, 1'b1, 6'd1, 32'h0, 1'b1, 6'd1, 6'd0, 16'h0);
    tick();
    idle();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.count} !== {6'h23, 32'hC, 3'd1}) begin
      $display("[TB] FAIL cnt1_enq_issue: ope/ds/count got %h/%h/%0d want 23/C/1", ifq.ope, ifq.ds_val, ifq.count);
      bad++;
    end
    tick();
    total++;
    if ({ifq.ope, ifq.ds_val, ifq.count} !== {6'h24, 32'hD, 3'd0}) begin
      $display("[TB] FAIL cnt1_last: ope/ds/count got %h/%h/%0d want 24/D/0", ifq.ope, ifq.ds_val, ifq.count);
      bad++;
    end
  endtask

  task automatic test_mid_reset();
    set_op(6'h08, 32'h0, 1'b0, 6'd50, 32'h0, 1'b1, 6'd1, 6'd4, 16'h0);
    tick();
    tick();
    idle();
    rstn = 1'b0;
    ifq.wb_tag = 6'd50;
    ifq.wb_val = 32'h1;
    tick();
    idle();
    rstn = 1'b1;
    total++;
    if ({ifq.count, ifq.ope, ifq.dd} !== {3'd0, 6'h00, 6'd0}) begin
      $display("[TB] FAIL mid_reset_clear: count/ope/dd got %0d/%h/%0d want 0/00/0", ifq.count, ifq.ope, ifq.dd);
      bad++;
    end
    tick();
    total++;
    if ({ifq.count, ifq.ope} !== {3'd0, 6'h00}) begin
      $display("[TB] FAIL mid_reset_no_issue: count/ope got %0d/%h want 0/00", ifq.count, ifq.ope);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    test_reset();
    test_ready_load();
    test_wakeup_order();
    test_same_cycle_capture();
    test_full_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
